motion_tracker: RTL

Parametrised successor to the per-axis heading detector in the ball/paddle datapath. Tracks N position axes sampled on a frame strobe and registers, per axis, the heading, the signed per-sample displacement, a one-cycle reversal (bounce) pulse and an optional stall flag. Sits between the ball position generator and the collision/scoring logic, which consume `reversal` and `heading` instead of re-deriving them.

---
 rtl/motion_pkg.sv | 17 +
 rtl/motion_axis.sv | 103 ++++++++++
 rtl/motion_tracker.sv | 88 ++++++++
 3 files changed

// File: rtl/motion_pkg.sv
// -----------------------------------------------------------------------------
// motion_pkg
// Shared types and constants for the motion_tracker block.
//   tracker_state_t : control FSM states (WARM = priming, TRACK = updating)
//   HEAD_INC/DEC    : heading encodings (1 = increasing, 0 = decreasing)
// -----------------------------------------------------------------------------
package motion_pkg;

  typedef enum logic {
    WARM  = 1'b0,
    TRACK = 1'b1
  } tracker_state_t;

  localparam logic HEAD_INC = 1'b1;
  localparam logic HEAD_DEC = 1'b0;

endpackage

// File: rtl/motion_axis.sv
// -----------------------------------------------------------------------------
// motion_axis
// One tracked position axis: previous position, signed displacement,
// dead-band compare, heading, reversal pulse and (optionally) a stall counter.
// Optional feature macro: MOTION_TRACKER_STALL_EN (stall counter present).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_load       : priming sample (loads prev only)
//   i_track      : tracking sample (updates delta/heading/reversal)
//   i_pos        : current unsigned position
//   o_heading    : 1 = increasing, 0 = decreasing
//   o_delta      : signed pos - prev, W+1 bits
//   o_reversal   : one-cycle pulse when the heading flips
//   o_stall      : axis stationary for at least STALL_N samples
// -----------------------------------------------------------------------------
module motion_axis
  import motion_pkg::*;
#(
  parameter int W       = 10,
  parameter int DEAD    = 0,
  parameter int STALL_N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_track,
  input  logic [W-1:0]      i_pos,
  output logic              o_heading,
  output logic signed [W:0] o_delta,
  output logic              o_reversal,
  output logic              o_stall
);

  localparam logic signed [W:0] DEAD_S = (W+1)'(DEAD);

  logic [W-1:0]      r_prev;
  logic              r_heading;
  logic signed [W:0] r_delta;
  logic              r_reversal;
  logic signed [W:0] w_d;
  logic              w_head_nxt;

  // Zero-extending both operands makes the difference exact over the full range.
  assign w_d = {1'b0, i_pos} - {1'b0, r_prev};

  always_comb begin
    w_head_nxt = r_heading;
    if (w_d > DEAD_S)
      w_head_nxt = HEAD_INC;
    else if (w_d < -DEAD_S)
      w_head_nxt = HEAD_DEC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev     <= '0;
      r_heading  <= HEAD_INC;
      r_delta    <= '0;
      r_reversal <= 1'b0;
    end else begin
      r_reversal <= 1'b0;
      if (i_load)
        r_prev <= i_pos;
      if (i_track) begin
        r_prev     <= i_pos;
        r_delta    <= w_d;
        r_heading  <= w_head_nxt;
        r_reversal <= (w_head_nxt != r_heading);
      end
    end
  end

`ifdef MOTION_TRACKER_STALL_EN
  localparam int CW = $clog2(STALL_N + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STALL_N);

  logic [CW-1:0] r_cnt;
  logic          w_still;

  assign w_still = (w_d <= DEAD_S) && (w_d >= -DEAD_S);

  // Saturating count of consecutive dead-band samples; motion clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_track) begin
      if (!w_still)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stall = (r_cnt == CNT_MAX);
`else
  assign o_stall = 1'b0;
`endif

  assign o_heading  = r_heading;
  assign o_delta    = r_delta;
  assign o_reversal = r_reversal;

endmodule

// File: rtl/motion_tracker.sv
// -----------------------------------------------------------------------------
// motion_tracker
// Tracks AXES unsigned positions sampled on a frame strobe and reports per-axis
// heading, signed displacement, reversal pulses and stall flags.
// Optional feature macro: MOTION_TRACKER_STALL_EN (per-axis stall counters;
// when undefined, stall is tied to 0).
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   sample   : frame strobe, pos captured when high
//   pos      : packed positions, axis i at [i*W +: W]
//   heading  : per-axis heading (1 = increasing)
//   delta    : packed signed displacement, axis i at [i*(W+1) +: W+1]
//   reversal : per-axis one-cycle heading-flip pulse
//   valid    : one-cycle pulse, outputs updated this cycle
//   stall    : per-axis stationary flag
// -----------------------------------------------------------------------------
module motion_tracker
  import motion_pkg::*;
#(
  parameter int W       = 10,
  parameter int AXES    = 2,
  parameter int DEAD    = 0,
  parameter int STALL_N = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample,
  input  logic [AXES*W-1:0]       pos,
  output logic [AXES-1:0]         heading,
  output logic [AXES*(W+1)-1:0]   delta,
  output logic [AXES-1:0]         reversal,
  output logic                    valid,
  output logic [AXES-1:0]         stall
);

  tracker_state_t r_state;
  tracker_state_t w_state_nxt;
  logic           w_load;
  logic           w_track;
  logic           r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= WARM;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_track;
    end
  end

  // The first sample after reset only primes prev; later samples track.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_track     = 1'b0;
    if (sample) begin
      if (r_state == WARM) begin
        w_load      = 1'b1;
        w_state_nxt = TRACK;
      end else begin
        w_track = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < AXES; gi++) begin : g_axis
    motion_axis #(
      .W       (W),
      .DEAD    (DEAD),
      .STALL_N (STALL_N)
    ) u_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_track    (w_track),
      .i_pos      (pos[gi*W +: W]),
      .o_heading  (heading[gi]),
      .o_delta    (delta[gi*(W+1) +: W+1]),
      .o_reversal (reversal[gi]),
      .o_stall    (stall[gi])
    );
  end

  assign valid = r_valid;

endmodule
